// File: rtl/store_rmw_unit_if.sv
// store_rmw_unit_if: store request from the datapath plus the word-wide data
// memory port, bundled into one interface.
// Build option STORE_BE_EN adds the mem_be_o byte-enable signal.
// Modports: slave = the store unit, master = the datapath/memory environment.
interface store_rmw_unit_if;
   logic        req_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [1:0]  size_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] mem_addr_o;
   logic        mem_rd_o;
   logic [31:0] mem_rdata_i;
   logic        mem_wr_o;
   logic [31:0] mem_wdata_o;
`ifdef STORE_BE_EN
   logic [3:0]  mem_be_o;
`endif

   modport slave (
      input  req_i, addr_i, wdata_i, size_i, mem_rdata_i,
      output busy_o, done_o, err_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o
`ifdef STORE_BE_EN
      , output mem_be_o
`endif
   );

   modport master (
      output req_i, addr_i, wdata_i, size_i, mem_rdata_i,
      input  busy_o, done_o, err_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o
`ifdef STORE_BE_EN
      , input mem_be_o
`endif
   );
endinterface

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: narrows sb/sh/sw store data onto a word-only data memory.
// Sub-word stores read the aligned word, replace the addressed lane and write
// the word back; the core is stalled through busy_o while this runs.
// Build option STORE_BE_EN: every legal store goes straight to a single write
// with the data replicated across lanes and byte enables on mem_be_o.
module store_rmw_unit #(
   parameter int unsigned MEM_RD_LAT = 1   // read latency in cycles, 1..7
) (
   input  logic            clk_i,
   input  logic            rst_i,          // asynchronous, active low
   store_rmw_unit_if.slave bus
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [2:0] RD_LAT  = 3'(MEM_RD_LAT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t     state;
   logic [2:0] wait_cnt;
`ifndef STORE_BE_EN
   // Only what the merge needs is kept: the lane, the size and the low half.
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic [15:0] wdata_q;
`endif

   // Misaligned half/word or the reserved size code.
   function automatic logic illegal_req(input logic [1:0] size,
                                        input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lane[0];
         SZ_WORD: return lane != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

`ifdef STORE_BE_EN
   // Store data copied into every lane it could land in.
   function automatic logic [31:0] replicate(input logic [31:0] data,
                                             input logic [1:0]  size);
      case (size)
         SZ_BYTE: return {4{data[7:0]}};
         SZ_HALF: return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   // Byte enables for the addressed lane(s), little-endian.
   function automatic logic [3:0] byte_en(input logic [1:0] size,
                                          input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 4'b0001 << lane;
         SZ_HALF: return 4'b0011 << {lane[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction
`else
   // Replace one byte or halfword lane of the word read from memory.
   function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                              input logic [15:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
      logic [31:0] word;
      // NOTE: starting from a full default before the case keeps every bit
      // assigned on every path, so no latch-like hold is implied.
      word = old_word;
      case (size)
         SZ_BYTE: word[{lane, 3'b000} +: 8]        = data[7:0];
         SZ_HALF: word[{lane[1], 4'b0000} +: 16]   = data;
         default: word                             = old_word;
      endcase
      return word;
   endfunction
`endif

   // Store sequencer: state, capture registers and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         // NOTE: every flop here is control or a small capture register, so
         // all of them are reset; an abort mid-operation leaves nothing stale.
         state           <= S_IDLE;
         wait_cnt        <= 3'd0;
         bus.busy_o      <= 1'b0;
         bus.done_o      <= 1'b0;
         bus.err_o       <= 1'b0;
         bus.mem_rd_o    <= 1'b0;
         bus.mem_wr_o    <= 1'b0;
         bus.mem_addr_o  <= 32'd0;
         bus.mem_wdata_o <= 32'd0;
`ifdef STORE_BE_EN
         bus.mem_be_o    <= 4'd0;
`else
         lane_q          <= 2'd0;
         size_q          <= 2'd0;
         wdata_q         <= 16'd0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the
         // pre-edge state; the strobes default low and are raised only on
         // entry to the state that owns them.
         bus.done_o   <= 1'b0;
         bus.err_o    <= 1'b0;
         bus.mem_rd_o <= 1'b0;
         bus.mem_wr_o <= 1'b0;
`ifdef STORE_BE_EN
         bus.mem_be_o <= 4'd0;
`endif
         case (state)
            S_IDLE: begin
               if (bus.req_i) begin
                  bus.busy_o     <= 1'b1;
                  bus.mem_addr_o <= {bus.addr_i[31:2], 2'b00};
`ifndef STORE_BE_EN
                  lane_q         <= bus.addr_i[1:0];
                  size_q         <= bus.size_i;
                  wdata_q        <= bus.wdata_i[15:0];
`endif
                  if (illegal_req(bus.size_i, bus.addr_i[1:0])) begin
                     state      <= S_DONE;
                     bus.done_o <= 1'b1;
                     bus.err_o  <= 1'b1;
`ifdef STORE_BE_EN
                  end else begin
                     state           <= S_WRITE;
                     bus.mem_wr_o    <= 1'b1;
                     bus.mem_wdata_o <= replicate(bus.wdata_i, bus.size_i);
                     bus.mem_be_o    <= byte_en(bus.size_i, bus.addr_i[1:0]);
                  end
`else
                  end else if (bus.size_i == SZ_WORD) begin
                     state           <= S_WRITE;
                     bus.mem_wr_o    <= 1'b1;
                     bus.mem_wdata_o <= bus.wdata_i;
                  end else begin
                     state        <= S_READ;
                     bus.mem_rd_o <= 1'b1;
                  end
`endif
               end
            end
            S_READ: begin
               state    <= S_WAIT;
               wait_cnt <= 3'd1;
            end
            S_WAIT: begin
               if (wait_cnt == RD_LAT) begin
                  state        <= S_WRITE;
                  bus.mem_wr_o <= 1'b1;
`ifndef STORE_BE_EN
                  bus.mem_wdata_o <= merge_word(bus.mem_rdata_i, wdata_q,
                                                size_q, lane_q);
`endif
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            S_WRITE: begin
               state      <= S_DONE;
               bus.done_o <= 1'b1;
            end
            S_DONE: begin
               state      <= S_IDLE;
               bus.busy_o <= 1'b0;
            end
            default: begin
               state      <= S_IDLE;
               bus.busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: two store units (read latency 1 and 3) share one stimulus
// stream of directed vectors with hand-computed results. Expected memory
// strobes and completions are queued per unit at issue time; a monitor pops
// and compares whenever a unit raises mem_rd_o, mem_wr_o or done_o.
// Honours STORE_BE_EN the same way the design does.
module tb_store_rmw_unit;

   typedef enum logic [1:0] {EV_RD, EV_WR, EV_DONE} ev_kind_t;

   typedef struct {
      ev_kind_t    kind;
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        err;
   } ev_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic [31:0] mem_word;
      logic [31:0] exp_rmw;   // merged word, read-modify-write build
      logic [31:0] exp_rep;   // replicated word, byte-enable build
      logic [3:0]  exp_be;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  size;
   logic [31:0] mem_word;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   ev_t         q1[$];
   ev_t         q3[$];
   vec_t        vecs[$];
   logic [7:0]  pipe1;
   logic [7:0]  pipe3;

   store_rmw_unit_if if1 ();
   store_rmw_unit_if if3 ();

   assign if1.req_i   = req;
   assign if1.addr_i  = addr;
   assign if1.wdata_i = wdata;
   assign if1.size_i  = size;
   assign if3.req_i   = req;
   assign if3.addr_i  = addr;
   assign if3.wdata_i = wdata;
   assign if3.size_i  = size;

   // Memory model: data is valid only in the cycle MEM_RD_LAT after the strobe.
   assign if1.mem_rdata_i = pipe1[0] ? mem_word : 32'hBAD0_BAD0;
   assign if3.mem_rdata_i = pipe3[2] ? mem_word : 32'hBAD0_BAD0;

   store_rmw_unit #(.MEM_RD_LAT(1)) dut1 (.clk_i(clk), .rst_i(rst_i), .bus(if1));
   store_rmw_unit #(.MEM_RD_LAT(3)) dut3 (.clk_i(clk), .rst_i(rst_i), .bus(if3));

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         pipe1 <= 8'd0;
         pipe3 <= 8'd0;
      end else begin
         pipe1 <= {pipe1[6:0], if1.mem_rd_o};
         pipe3 <= {pipe3[6:0], if3.mem_rd_o};
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic push(input int inst, input ev_kind_t kind, input int c,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic err);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.addr = a;
      e.data = d;
      e.be   = be;
      e.err  = err;
      if (inst == 1) q1.push_back(e);
      else           q3.push_back(e);
   endtask

   // Expected events for one accepted request; inst doubles as the read latency.
   task automatic expect_vec(input vec_t v, input int t0, input int inst);
      logic [31:0] wa;
      wa = {v.addr[31:2], 2'b00};
      if (v.exp_err) begin
         push(inst, EV_DONE, t0 + 1, 32'd0, 32'd0, 4'd0, 1'b1);
      end else begin
`ifdef STORE_BE_EN
         push(inst, EV_WR,   t0 + 1, wa, v.exp_rep, v.exp_be, 1'b0);
         push(inst, EV_DONE, t0 + 2, 32'd0, 32'd0, 4'd0, 1'b0);
`else
         if (v.size == 2'b10) begin
            push(inst, EV_WR,   t0 + 1, wa, v.exp_rmw, 4'd0, 1'b0);
            push(inst, EV_DONE, t0 + 2, 32'd0, 32'd0, 4'd0, 1'b0);
         end else begin
            push(inst, EV_RD,   t0 + 1, wa, 32'd0, 4'd0, 1'b0);
            push(inst, EV_WR,   t0 + 2 + inst, wa, v.exp_rmw, 4'd0, 1'b0);
            push(inst, EV_DONE, t0 + 3 + inst, 32'd0, 32'd0, 4'd0, 1'b0);
         end
`endif
      end
   endtask

   // Scoreboard side: pop the next expected event of a unit and compare.
   task automatic take(input int inst, input ev_kind_t kind,
                       input logic [31:0] maddr, input logic [31:0] mdata,
                       input logic err);
      ev_t   e;
      string tag;
      bit    have;
      tag  = $sformatf("lat%0d_%s", inst, kind.name());
      have = (inst == 1) ? (q1.size() != 0) : (q3.size() != 0);
      if (!have) begin
         checks++;
         failures++;
         $display("FAIL %s_unexpected: actual=strobe at cycle %0d required=no strobe",
                  tag, cyc);
         return;
      end
      if (inst == 1) e = q1.pop_front();
      else           e = q3.pop_front();
      check({tag, "_kind"},  32'(kind), 32'(e.kind));
      check({tag, "_cycle"}, cyc, e.cyc);
      case (kind)
         EV_RD: check({tag, "_addr"}, maddr, e.addr);
         EV_WR: begin
            check({tag, "_addr"},  maddr, e.addr);
            check({tag, "_wdata"}, mdata, e.data);
`ifdef STORE_BE_EN
            check({tag, "_be"}, (inst == 1) ? if1.mem_be_o : if3.mem_be_o, e.be);
`endif
         end
         default: begin
            check({tag, "_err"}, err, e.err);
`ifdef STORE_BE_EN
            check({tag, "_be_idle"}, (inst == 1) ? if1.mem_be_o : if3.mem_be_o, 4'd0);
`endif
         end
      endcase
   endtask

   // Monitor: one comparison group per strobe the units present.
   always @(negedge clk) begin
      if (if1.mem_rd_o) take(1, EV_RD,   if1.mem_addr_o, if1.mem_wdata_o, if1.err_o);
      if (if1.mem_wr_o) take(1, EV_WR,   if1.mem_addr_o, if1.mem_wdata_o, if1.err_o);
      if (if1.done_o)   take(1, EV_DONE, if1.mem_addr_o, if1.mem_wdata_o, if1.err_o);
      if (if3.mem_rd_o) take(3, EV_RD,   if3.mem_addr_o, if3.mem_wdata_o, if3.err_o);
      if (if3.mem_wr_o) take(3, EV_WR,   if3.mem_addr_o, if3.mem_wdata_o, if3.err_o);
      if (if3.done_o)   take(3, EV_DONE, if3.mem_addr_o, if3.mem_wdata_o, if3.err_o);
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy1"},  if1.busy_o,      32'd0);
      check({tag, "_done1"},  if1.done_o,      32'd0);
      check({tag, "_err1"},   if1.err_o,       32'd0);
      check({tag, "_rd1"},    if1.mem_rd_o,    32'd0);
      check({tag, "_wr1"},    if1.mem_wr_o,    32'd0);
      check({tag, "_addr1"},  if1.mem_addr_o,  32'd0);
      check({tag, "_wdata1"}, if1.mem_wdata_o, 32'd0);
      check({tag, "_busy3"},  if3.busy_o,      32'd0);
      check({tag, "_rd3"},    if3.mem_rd_o,    32'd0);
      check({tag, "_wr3"},    if3.mem_wr_o,    32'd0);
      check({tag, "_addr3"},  if3.mem_addr_o,  32'd0);
      check({tag, "_wdata3"}, if3.mem_wdata_o, 32'd0);
`ifdef STORE_BE_EN
      check({tag, "_be1"}, if1.mem_be_o, 32'd0);
      check({tag, "_be3"}, if3.mem_be_o, 32'd0);
`endif
   endtask

   // Bounded wait until both units are idle with nothing left outstanding.
   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((q1.size() != 0 || q3.size() != 0 || if1.busy_o || if3.busy_o)
             && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drained1"}, q1.size(), 32'd0);
      check({tag, "_drained3"}, q3.size(), 32'd0);
      check({tag, "_idle1"},    if1.busy_o, 32'd0);
      check({tag, "_idle3"},    if3.busy_o, 32'd0);
   endtask

   // Issue one vector; b2b keeps req high so a second copy is accepted in the
   // IDLE cycle right after DONE, and the busy cycles in between are ignored.
   task automatic issue(input int idx, input bit b2b);
      vec_t  v;
      int    t0;
      string tag;
      v   = vecs[idx];
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      mem_word = v.mem_word;
      addr     = v.addr;
      wdata    = v.wdata;
      size     = v.size;
      req      = 1'b1;
      t0       = cyc;
      expect_vec(v, t0, 1);
      expect_vec(v, t0, 3);
      if (b2b) begin
         expect_vec(v, t0 + 3, 1);
         expect_vec(v, t0 + 3, 3);
      end
      @(negedge clk);
      check({tag, "_busy1"}, if1.busy_o, 32'd1);
      check({tag, "_busy3"}, if3.busy_o, 32'd1);
      if (b2b) repeat (3) @(negedge clk);
      req = 1'b0;
      wait_idle(tag);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s, input logic [31:0] m,
                               input logic [31:0] rmw, input logic [31:0] rep,
                               input logic [3:0] be, input logic err);
      vec_t v;
      v.addr = a; v.wdata = d; v.size = s; v.mem_word = m;
      v.exp_rmw = rmw; v.exp_rep = rep; v.exp_be = be; v.exp_err = err;
      return v;
   endfunction

   // Reset in the middle of a byte store: everything clears at once and no
   // write ever follows.
   task automatic reset_mid_op();
      vec_t v;
      v = vecs[1];
      @(negedge clk);
      mem_word = v.mem_word;
      addr     = v.addr;
      wdata    = v.wdata;
      size     = v.size;
      req      = 1'b1;
`ifdef STORE_BE_EN
      @(posedge clk);
      #1;
      req = 1'b0;
`else
      push(1, EV_RD, cyc + 1, {v.addr[31:2], 2'b00}, 32'd0, 4'd0, 1'b0);
      push(3, EV_RD, cyc + 1, {v.addr[31:2], 2'b00}, 32'd0, 4'd0, 1'b0);
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
`endif
      check("rst_pre_busy1", if1.busy_o, 32'd1);
      check("rst_pre_busy3", if3.busy_o, 32'd1);
      rst_i = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      repeat (8) @(negedge clk);
      check("rst_after_q1",    q1.size(),  32'd0);
      check("rst_after_q3",    q3.size(),  32'd0);
      check("rst_after_busy1", if1.busy_o, 32'd0);
      check("rst_after_busy3", if3.busy_o, 32'd0);
   endtask

   initial begin
      rst_i    = 1'b0;
      req      = 1'b0;
      addr     = 32'd0;
      wdata    = 32'd0;
      size     = 2'd0;
      mem_word = 32'd0;

      //             addr          wdata         sz     mem word      rmw result    replicated    be       err
      vecs.push_back(mk(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 32'h1122_3344, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 1'b0));
      vecs.push_back(mk(32'h0000_0103, 32'h0000_00AB, 2'b00, 32'h1122_3344, 32'hAB22_3344, 32'hABAB_ABAB, 4'b1000, 1'b0));
      vecs.push_back(mk(32'h0000_0202, 32'h0000_CAFE, 2'b01, 32'h1122_3344, 32'hCAFE_3344, 32'hCAFE_CAFE, 4'b1100, 1'b0));
      vecs.push_back(mk(32'h0000_0201, 32'h0000_CAFE, 2'b01, 32'h1122_3344, 32'h0,         32'h0,         4'b0000, 1'b1));
      vecs.push_back(mk(32'h0000_0102, 32'hDEAD_BEEF, 2'b10, 32'h1122_3344, 32'h0,         32'h0,         4'b0000, 1'b1));
      vecs.push_back(mk(32'h0000_0300, 32'h1234_5678, 2'b11, 32'h1122_3344, 32'h0,         32'h0,         4'b0000, 1'b1));
      vecs.push_back(mk(32'h0000_0101, 32'h0000_005A, 2'b00, 32'h1122_3344, 32'h1122_5A44, 32'h5A5A_5A5A, 4'b0010, 1'b0));
      vecs.push_back(mk(32'h0000_0200, 32'h1234_BEEF, 2'b01, 32'hA5A5_A5A5, 32'hA5A5_BEEF, 32'hBEEF_BEEF, 4'b0011, 1'b0));
      vecs.push_back(mk(32'h0000_0100, 32'hFFFF_FF77, 2'b00, 32'h0000_0000, 32'h0000_0077, 32'h7777_7777, 4'b0001, 1'b0));
      vecs.push_back(mk(32'h0000_0102, 32'h0000_00C3, 2'b00, 32'hFFFF_FFFF, 32'hFFC3_FFFF, 32'hC3C3_C3C3, 4'b0100, 1'b0));
      vecs.push_back(mk(32'h0000_0004, 32'h0123_4567, 2'b10, 32'h1122_3344, 32'h0123_4567, 32'h0123_4567, 4'b1111, 1'b0));
      vecs.push_back(mk(32'hFFFF_FFFE, 32'h0000_1357, 2'b01, 32'h89AB_CDEF, 32'h1357_CDEF, 32'h1357_1357, 4'b1100, 1'b0));

      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      rst_i = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) issue(i, 1'b0);
      issue(10, 1'b1);
      reset_mid_op();
      issue(6, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
